seq_restoring_divider: RTL and testbench

- Sequential restoring divider that inverts the team's 4x4 array multiplier: an unsigned 8-bit dividend divided by a 4-bit divisor gives an 8-bit quotient and a 4-bit remainder.
- Produces one quotient bit per clock and uses a start/busy/done handshake.
- Sits beside the multiplier in the arithmetic tile and shares its operand pin mapping at top level.

---
 rtl/div_pkg.sv | 26 ++
 rtl/div_step.sv | 24 ++
 rtl/seq_restoring_divider.sv | 124 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Holds the FSM state encoding, default widths and a count-width helper.
package div_pkg;

   localparam int DW_DEF = 8;
   localparam int VW_DEF = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r = r + 1;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, trial
// subtract the divisor, keep the difference only if it is non-negative.
module div_step #(
   parameter int VW = 4
) (
   input  logic [VW:0]   r_i,
   input  logic          bit_i,
   input  logic [VW-1:0] divisor_i,
   output logic [VW:0]   r_o,
   output logic          q_o
);

   logic [VW+1:0] rp;
   logic [VW+1:0] t;

   // r[VW] is always 0 between steps, so widening r' by it is harmless
   always_comb begin
      rp  = {r_i, bit_i};
      t   = rp - {2'b00, divisor_i};
      q_o = ~t[VW+1];
      r_o = q_o ? t[VW:0] : rp[VW:0];
   end

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned DW/VW restoring divider, one quotient bit per clock.
// start/busy/done handshake; divide-by-zero returns all ones at once.
module seq_restoring_divider
   import div_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int VW = VW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [DW-1:0] dividend,
   input  logic [VW-1:0] divisor,
   output logic [DW-1:0] quotient,
   output logic [VW-1:0] remainder,
   output logic          busy,
   output logic          done,
   output logic          div_by_zero
);

   localparam int CW = (clog2(DW) < 1) ? 1 : clog2(DW);
   localparam logic [CW-1:0] CNT_INIT = CW'(DW - 1);

   state_e        state_q, state_d;
   logic [DW-1:0] shift_q, shift_d;
   logic [VW:0]   r_q, r_d;
   logic [VW-1:0] dv_q, dv_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [DW-1:0] quot_q, quot_d;
   logic [VW-1:0] rem_q, rem_d;
   logic          dbz_q, dbz_d;

   logic [VW:0]   r_nx;
   logic          qbit;
   logic [DW-1:0] shift_nx;

   div_step #(.VW(VW)) u_step (
      .r_i       (r_q),
      .bit_i     (shift_q[DW-1]),
      .divisor_i (dv_q),
      .r_o       (r_nx),
      .q_o       (qbit)
   );

   assign shift_nx = {shift_q[DW-2:0], qbit};

   // Next-state logic: capture, iterate, publish result on entry to DONE
   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      r_d     = r_q;
      dv_d    = dv_q;
      cnt_d   = cnt_q;
      quot_d  = quot_q;
      rem_d   = rem_q;
      dbz_d   = dbz_q;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               if (divisor != '0) begin
                  shift_d = dividend;
                  dv_d    = divisor;
                  r_d     = '0;
                  cnt_d   = CNT_INIT;
                  dbz_d   = 1'b0;
                  state_d = RUN;
               end else begin
                  quot_d  = '1;
                  rem_d   = '1;
                  dbz_d   = 1'b1;
                  state_d = DONE;
               end
            end
         end
         RUN: begin
            r_d     = r_nx;
            shift_d = shift_nx;
            if (cnt_q == '0) begin
               quot_d  = shift_nx;
               rem_d   = r_nx[VW-1:0];
               state_d = DONE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and result registers, cleared asynchronously
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         shift_q <= '0;
         r_q     <= '0;
         dv_q    <= '0;
         cnt_q   <= '0;
         quot_q  <= '0;
         rem_q   <= '0;
         dbz_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         r_q     <= r_d;
         dv_q    <= dv_d;
         cnt_q   <= cnt_d;
         quot_q  <= quot_d;
         rem_q   <= rem_d;
         dbz_q   <= dbz_d;
      end
   end

   assign quotient    = quot_q;
   assign remainder   = rem_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == DONE);
   assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and sweep checks for seq_restoring_divider.
// Inputs driven on negedge, outputs sampled on negedge.
module tb_seq_restoring_divider;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       start = 1'b0;
   logic [7:0] dividend = '0;
   logic [3:0] divisor = '0;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       busy;
   logic       done;
   logic       div_by_zero;

   int total = 0;
   int bad = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   seq_restoring_divider dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic launch(input logic [7:0] dd, input logic [3:0] dv,
                         output int ts);
      dividend = dd;
      divisor  = dv;
      start    = 1'b1;
      @(posedge clk);
      #1 ts = cyc;
      @(negedge clk);
      start    = 1'b0;
      dividend = ~dd;
      divisor  = dv ^ 4'h5;
   endtask

   task automatic wait_done(output int lat, output int bc);
      lat = 1;
      bc  = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(negedge clk);
         lat++;
         if (busy) bc++;
      end
      chk("done_seen", done, 1);
   endtask

   int ev_dd[5] = '{255, 0, 13, 15, 255};
   int ev_dv[5] = '{1, 9, 14, 15, 15};
   int ev_q[5]  = '{255, 0, 0, 1, 17};
   int ev_r[5]  = '{0, 0, 13, 0, 0};

   initial begin
      int lat, bc, ts1, ts2, dn;
      logic [7:0] eq;
      logic [3:0] er;

      #2 rst_n = 1'b0;
      #10;
      chk("rst_q", quotient, 0);
      chk("rst_r", remainder, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_dbz", div_by_zero, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      launch(8'd200, 4'd7, ts1);
      wait_done(lat, bc);
      chk("n_lat", lat, 9);
      chk("n_busy", bc, 9);
      chk("n_q", quotient, 28);
      chk("n_r", remainder, 4);
      chk("n_dbz", div_by_zero, 0);
      @(negedge clk);
      chk("n_pulse", done, 0);
      chk("n_idle", busy, 0);
      chk("n_holdq", quotient, 28);

      for (int i = 0; i < 5; i++) begin
         launch(8'(ev_dd[i]), 4'(ev_dv[i]), ts1);
         wait_done(lat, bc);
         chk("edge_q", quotient, ev_q[i]);
         chk("edge_r", remainder, ev_r[i]);
         @(negedge clk);
      end

      launch(8'd100, 4'd0, ts1);
      wait_done(lat, bc);
      chk("z_lat", lat, 1);
      chk("z_q", quotient, 255);
      chk("z_r", remainder, 15);
      chk("z_dbz", div_by_zero, 1);
      chk("z_busy", busy, 1);
      @(negedge clk);
      launch(8'd50, 4'd5, ts1);
      chk("z_hold", quotient, 255);
      chk("z_clr", div_by_zero, 0);
      wait_done(lat, bc);
      chk("z2_q", quotient, 10);
      chk("z2_r", remainder, 0);
      chk("z2_dbz", div_by_zero, 0);
      @(negedge clk);

      launch(8'd200, 4'd7, ts1);
      repeat (3) @(negedge clk);
      dividend = 8'd9;
      divisor  = 4'd3;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done(lat, bc);
      chk("sb_q", quotient, 28);
      chk("sb_r", remainder, 4);
      dn = 0;
      repeat (15) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("sb_extra", dn, 0);

      launch(8'd99, 4'd10, ts1);
      wait_done(lat, bc);
      chk("bb1_q", quotient, 9);
      chk("bb1_r", remainder, 9);
      @(negedge clk);
      launch(8'd64, 4'd8, ts2);
      chk("bb_period", ts2 - ts1, 10);
      wait_done(lat, bc);
      chk("bb2_q", quotient, 8);
      chk("bb2_r", remainder, 0);
      @(negedge clk);

      launch(8'd200, 4'd7, ts1);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("mr_q", quotient, 0);
      chk("mr_r", remainder, 0);
      chk("mr_busy", busy, 0);
      dn = 0;
      repeat (3) begin
         @(negedge clk);
         if (done) dn++;
      end
      rst_n = 1'b1;
      repeat (12) begin
         @(negedge clk);
         if (done) dn++;
      end
      chk("mr_nodone", dn, 0);
      chk("mr_idle", busy, 0);
      launch(8'd77, 4'd6, ts1);
      wait_done(lat, bc);
      chk("mr2_q", quotient, 12);
      chk("mr2_r", remainder, 5);
      @(negedge clk);

      for (int a = 0; a < 256; a++) begin
         for (int b = 1; b < 16; b++) begin
            launch(8'(a), 4'(b), ts1);
            wait_done(lat, bc);
            eq = 8'(a / b);
            er = 4'(a % b);
            chk("sweep", {quotient, remainder}, {eq, er});
            @(negedge clk);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
